clock_set_ctrl: RTL and testbench
=================================

Name: clock_set_ctrl

Overview:
Mode and setting sequencer for the digital clock datapath (seconds/minutes/hours counters and HEX5..HEX0 display). Walks the clock through NORMAL -> SET_SEC -> SET_MIN -> SET_HOUR on the mode key. Converts KEY0 (up) and KEY3 (down) presses into single-cycle increment/decrement pulses for the selected field, with hold-to-repeat. Also produces per-field freeze enables and a blink mask for the field being set.

Parameters:
REPEAT_DELAY, 25000000, cycles a key must be held before auto-repeat starts (0.5 s at 50 MHz)
REPEAT_PERIOD, 5000000, cycles between auto-repeat pulses
BLINK_HALF, 12500000, cycles per blink half-period
TIMEOUT, 500000000, idle cycles in any SET mode before returning to NORMAL
CNT_W, 29, width of every internal timer

Ports:
CLOCK_50  input  1  system clock; the only clock
reset  input  1  asynchronous, active-high reset
trans  input  1  mode key level, active-high, synchronized and debounced upstream
key_up_n  input  1  KEY0 level, active-low, synchronized and debounced
key_dn_n  input  1  KEY3 level, active-low, synchronized and debounced
mode  output  2  current mode: 0 NORMAL, 1 SET_SEC, 2 SET_MIN, 3 SET_HOUR
inc  output  3  {hour,min,sec} one-cycle increment pulses
dec  output  3  {hour,min,sec} one-cycle decrement pulses
freeze  output  3  {hour,min,sec}; 1 stops that field's free-running count
blank  output  6  HEX5..HEX0 blanking mask; 1 blanks the digit

Behaviour:
- Reset (async, any time, including mid-repeat): mode=NORMAL, inc=dec=freeze=blank=0, all timers 0, edge registers loaded as "released" (trans=0, keys=1), lockouts cleared.
- Mode FSM: a rising edge of trans advances NORMAL->SET_SEC->SET_MIN->SET_HOUR->NORMAL. If trans is sampled high at edge k and low at edge k-1, mode holds the new value after edge k+1. Holding trans high advances exactly once.
- Timeout: in SET modes, the idle timer counts every cycle with no key held and no trans edge. When it reaches TIMEOUT-1, mode goes to NORMAL. Key or trans activity clears it. The timer is held at 0 in NORMAL.
- freeze: one-hot on the field matching mode; 0 in NORMAL.
- Press: a key sampled low with the previous sample high. The matching pulse (inc or dec, on the selected field bit) is high in the cycle following that edge, for exactly one cycle.
- Repeat: while a key stays held, its hold timer counts. The first repeat pulse fires REPEAT_DELAY cycles after the press pulse; further pulses follow every REPEAT_PERIOD cycles. Release clears the timer.
- Both keys held: no pulses; both hold timers held at 0 until one key is released. The key still held then restarts from a fresh REPEAT_DELAY.
- In NORMAL, keys produce no pulses.
- Mode change while a key is held: that key is locked out (no pulses, timer 0) until it is released.
- inc and dec are never both nonzero, and at most one bit is set in each.
- Blink: the phase register is cleared on every mode change and on every inc/dec pulse. It toggles every BLINK_HALF cycles.
- blank bit pairs: SET_HOUR drives bits [5:4], SET_MIN drives [3:2], SET_SEC drives [1:0]; each pair equals the phase. All other bits are 0, and all are 0 in NORMAL.
- Wrap-around of field values is the datapath's job; this block only issues pulses.
- Timers saturate and never wrap.

Decomposition:
- Package clock_ctrl_pkg: mode encodings MODE_NORMAL/MODE_SET_SEC/MODE_SET_MIN/MODE_SET_HOUR, field index constants FLD_SEC=0/FLD_MIN=1/FLD_HOUR=2, and the mode-to-one-hot and mode-to-blank-pair functions.
- Sub-module key_repeat, instantiated twice (up, down). It contains the edge detect, lockout, hold timer and repeat pulse generation, with inputs key_n, enable, inhibit, lock_req and output pulse.
- The top level holds the mode FSM, idle timer, blink timer and output steering.

Test Plan:
Use overrides REPEAT_DELAY=8, REPEAT_PERIOD=4, BLINK_HALF=5, TIMEOUT=50.
1. Reset pulse, then 4 trans pulses of 3 cycles each, 10 cycles apart -> mode goes 1,2,3,0, one edge+1 cycle after each rise. freeze goes 001,010,100,000. inc and dec stay 0.
2. SET_MIN, key_up_n low for 1 cycle, then high -> inc=010 for exactly 1 cycle. No dec. blank[3:2] reads 00 for the next 5 cycles.
3. SET_SEC, key_dn_n held low 25 cycles -> dec=001 pulses at press+1, +9, +13, +17, +21, +25: 6 pulses total.
4. SET_HOUR, both keys low for 20 cycles -> no pulses. Release key_up_n -> dec=100 pulses after 8 more cycles.
5. SET_SEC with no activity -> mode=0 after 50 idle cycles, freeze=000, blank=0. In NORMAL with key_up_n held 30 cycles -> no pulses.
6. SET_MIN, key_up_n held, then assert reset mid-repeat -> all outputs 0 immediately (asynchronously). After reset drops with the key still low, no pulse until the key is released and pressed again.

Source files
------------

// File: rtl/clock_ctrl_pkg.sv
// Shared mode encodings and field-steering helpers for the clock set controller.
// Fields are ordered {hour,min,sec} in every 3-bit vector and HEX5..HEX0 in blank.
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_NORMAL   = 2'd0,
        MODE_SET_SEC  = 2'd1,
        MODE_SET_MIN  = 2'd2,
        MODE_SET_HOUR = 2'd3
    } mode_t;

    localparam int FLD_SEC  = 0;
    localparam int FLD_MIN  = 1;
    localparam int FLD_HOUR = 2;

    function automatic mode_t next_mode(input mode_t m);
        mode_t n;
        case (m)
            MODE_NORMAL:   n = MODE_SET_SEC;
            MODE_SET_SEC:  n = MODE_SET_MIN;
            MODE_SET_MIN:  n = MODE_SET_HOUR;
            default:       n = MODE_NORMAL;
        endcase
        return n;
    endfunction

    function automatic logic [2:0] mode_to_onehot(input mode_t m);
        logic [2:0] oh;
        oh = 3'b000;
        case (m)
            MODE_SET_SEC:  oh[FLD_SEC]  = 1'b1;
            MODE_SET_MIN:  oh[FLD_MIN]  = 1'b1;
            MODE_SET_HOUR: oh[FLD_HOUR] = 1'b1;
            default:       oh = 3'b000;
        endcase
        return oh;
    endfunction

    // Each field owns two adjacent digits; only the field being set blinks.
    function automatic logic [5:0] mode_to_blank(input mode_t m, input logic phase);
        logic [5:0] b;
        b = 6'b000000;
        case (m)
            MODE_SET_SEC:  b[1:0] = {2{phase}};
            MODE_SET_MIN:  b[3:2] = {2{phase}};
            MODE_SET_HOUR: b[5:4] = {2{phase}};
            default:       b = 6'b000000;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/key_repeat.sv
// Turns one active-low key level into a press pulse plus hold-to-repeat pulses,
// with suppression while the other key is held and lockout across mode changes.
module key_repeat
    import clock_ctrl_pkg::*;
#(
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000,
    parameter int CNT_W         = 29
) (
    input  logic clock,
    input  logic reset,
    input  logic key_n,
    input  logic enable,
    input  logic inhibit,
    input  logic lock_req,
    output logic pulse
);

    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic             key_prev;
    logic             locked;
    logic             repeating;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_limit;

    assign hold_limit = repeating ? PERIOD_LAST : DELAY_LAST;

    // A held key that is locked, disabled or inhibited keeps its timer at zero,
    // so it restarts from a full delay once it becomes eligible again.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            key_prev  <= 1'b1;
            locked    <= 1'b0;
            repeating <= 1'b0;
            hold_cnt  <= '0;
            pulse     <= 1'b0;
        end else begin
            key_prev <= key_n;
            pulse    <= 1'b0;
            if (key_n) begin
                locked    <= 1'b0;
                repeating <= 1'b0;
                hold_cnt  <= '0;
            end else if (lock_req || locked) begin
                locked    <= 1'b1;
                repeating <= 1'b0;
                hold_cnt  <= '0;
            end else if (!enable || inhibit) begin
                repeating <= 1'b0;
                hold_cnt  <= '0;
            end else if (key_prev) begin
                pulse     <= 1'b1;
                repeating <= 1'b0;
                hold_cnt  <= '0;
            end else if (hold_cnt == hold_limit) begin
                pulse     <= 1'b1;
                repeating <= 1'b1;
                hold_cnt  <= '0;
            end else if (hold_cnt != '1) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Mode and setting sequencer for the digital clock: mode FSM, idle timeout,
// blink timing and steering of up/down key pulses onto the selected field.
module clock_set_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000,
    parameter int BLINK_HALF    = 12500000,
    parameter int TIMEOUT       = 500000000,
    parameter int CNT_W         = 29
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       trans,
    input  logic       key_up_n,
    input  logic       key_dn_n,
    output logic [1:0] mode,
    output logic [2:0] inc,
    output logic [2:0] dec,
    output logic [2:0] freeze,
    output logic [5:0] blank
);

    localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_HALF - 1);

    mode_t            mode_q;
    logic             trans_prev;
    logic             trans_rise;
    logic [CNT_W-1:0] idle_cnt;
    logic [CNT_W-1:0] blink_cnt;
    logic             blink_phase;
    logic             up_pulse;
    logic             dn_pulse;
    logic             set_active;
    logic             key_active;
    logic             timeout_hit;
    logic             mode_change;
    logic [2:0]       field_oh;

    assign set_active  = (mode_q != MODE_NORMAL);
    assign key_active  = ~key_up_n | ~key_dn_n;
    assign timeout_hit = set_active && !trans_rise && !key_active && (idle_cnt == IDLE_LAST);
    assign mode_change = trans_rise | timeout_hit;

    // The registered rise adds one cycle, so mode lands two edges after trans goes high.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            trans_prev <= 1'b0;
            trans_rise <= 1'b0;
        end else begin
            trans_prev <= trans;
            trans_rise <= trans & ~trans_prev;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            mode_q <= MODE_NORMAL;
        end else if (trans_rise) begin
            mode_q <= next_mode(mode_q);
        end else if (timeout_hit) begin
            mode_q <= MODE_NORMAL;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            idle_cnt <= '0;
        end else if (!set_active || trans_rise || key_active || timeout_hit) begin
            idle_cnt <= '0;
        end else if (idle_cnt != '1) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    // Restarting the blink on every change keeps the edited digits visible right after a step.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (mode_change || up_pulse || dn_pulse) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else if (blink_cnt != '1) begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    key_repeat #(
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD),
        .CNT_W         (CNT_W)
    ) u_key_up (
        .clock    (CLOCK_50),
        .reset    (reset),
        .key_n    (key_up_n),
        .enable   (set_active),
        .inhibit  (~key_dn_n),
        .lock_req (mode_change),
        .pulse    (up_pulse)
    );

    key_repeat #(
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD),
        .CNT_W         (CNT_W)
    ) u_key_dn (
        .clock    (CLOCK_50),
        .reset    (reset),
        .key_n    (key_dn_n),
        .enable   (set_active),
        .inhibit  (~key_up_n),
        .lock_req (mode_change),
        .pulse    (dn_pulse)
    );

    assign field_oh = mode_to_onehot(mode_q);
    assign mode     = mode_q;
    assign freeze   = field_oh;
    assign inc      = up_pulse ? field_oh : 3'b000;
    assign dec      = dn_pulse ? field_oh : 3'b000;
    assign blank    = mode_to_blank(mode_q, blink_phase);

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with short timer overrides; each task
// drives one scenario and compares outputs against hand-computed values.
module tb_clock_set_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       trans = 1'b0;
    logic       key_up_n = 1'b1;
    logic       key_dn_n = 1'b1;
    logic [1:0] mode;
    logic [2:0] inc;
    logic [2:0] dec;
    logic [2:0] freeze;
    logic [5:0] blank;

    int tests_run = 0;
    int tests_failed = 0;

    clock_set_ctrl #(
        .REPEAT_DELAY  (8),
        .REPEAT_PERIOD (4),
        .BLINK_HALF    (5),
        .TIMEOUT       (50),
        .CNT_W         (29)
    ) dut (
        .CLOCK_50 (clock),
        .reset    (reset),
        .trans    (trans),
        .key_up_n (key_up_n),
        .key_dn_n (key_dn_n),
        .mode     (mode),
        .inc      (inc),
        .dec      (dec),
        .freeze   (freeze),
        .blank    (blank)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        trans    = 1'b0;
        key_up_n = 1'b1;
        key_dn_n = 1'b1;
        reset    = 1'b1;
        #2;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic advance_mode();
        trans = 1'b1;
        tick(1);
        trans = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if ({mode, inc, dec, freeze, blank} !== 17'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_async: got %h expected 0", {mode, inc, dec, freeze, blank});
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        tick(3);
        tests_run++;
        if ({mode, inc, dec, freeze, blank} !== 17'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_idle: got %h expected 0", {mode, inc, dec, freeze, blank});
        end
    endtask

    task automatic test_mode_cycle();
        logic [1:0] exp_mode [4];
        logic [2:0] exp_frz [4];
        logic [1:0] prev_mode;
        exp_mode = '{2'd1, 2'd2, 2'd3, 2'd0};
        exp_frz  = '{3'b001, 3'b010, 3'b100, 3'b000};
        do_reset();
        prev_mode = 2'd0;
        for (int i = 0; i < 4; i++) begin
            trans = 1'b1;
            tick(1);
            tests_run++;
            if (mode !== prev_mode) begin
                tests_failed++;
                $display("[TB] FAIL mode_early[%0d]: got %0d expected %0d", i, mode, prev_mode);
            end
            tick(1);
            tests_run++;
            if (mode !== exp_mode[i] || freeze !== exp_frz[i]) begin
                tests_failed++;
                $display("[TB] FAIL mode_step[%0d]: got mode %0d freeze %b expected mode %0d freeze %b",
                         i, mode, freeze, exp_mode[i], exp_frz[i]);
            end
            tick(1);
            trans = 1'b0;
            tests_run++;
            if (mode !== exp_mode[i] || inc !== 3'b000 || dec !== 3'b000) begin
                tests_failed++;
                $display("[TB] FAIL mode_hold[%0d]: got mode %0d inc %b dec %b expected mode %0d inc 000 dec 000",
                         i, mode, inc, dec, exp_mode[i]);
            end
            tick(7);
            prev_mode = exp_mode[i];
        end
    endtask

    task automatic test_single_press();
        do_reset();
        advance_mode();
        advance_mode();
        tests_run++;
        if (mode !== 2'd2) begin
            tests_failed++;
            $display("[TB] FAIL press_mode: got %0d expected 2", mode);
        end
        key_up_n = 1'b0;
        tick(1);
        tests_run++;
        if (inc !== 3'b010 || dec !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL press_pulse: got inc %b dec %b expected inc 010 dec 000", inc, dec);
        end
        key_up_n = 1'b1;
        tick(1);
        tests_run++;
        if (inc !== 3'b000 || dec !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL press_width: got inc %b dec %b expected 000 000", inc, dec);
        end
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) tick(1);
            tests_run++;
            if (blank !== 6'b000000) begin
                tests_failed++;
                $display("[TB] FAIL blink_clear[%0d]: got %b expected 000000", k, blank);
            end
        end
        tick(1);
        tests_run++;
        if (blank !== 6'b001100) begin
            tests_failed++;
            $display("[TB] FAIL blink_on: got %b expected 001100", blank);
        end
        tick(5);
        tests_run++;
        if (blank !== 6'b000000) begin
            tests_failed++;
            $display("[TB] FAIL blink_off: got %b expected 000000", blank);
        end
    endtask

    task automatic test_repeat();
        logic [5:0] exp_pulse;
        int pulses;
        do_reset();
        advance_mode();
        pulses = 0;
        key_dn_n = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            tick(1);
            exp_pulse = (k == 1 || k == 9 || k == 13 || k == 17 || k == 21 || k == 25)
                        ? 6'b000001 : 6'b000000;
            if (dec !== 3'b000) pulses++;
            tests_run++;
            if ({inc, dec} !== exp_pulse) begin
                tests_failed++;
                $display("[TB] FAIL repeat[%0d]: got inc,dec %b expected %b", k, {inc, dec}, exp_pulse);
            end
            if (k == 25) key_dn_n = 1'b1;
        end
        tests_run++;
        if (pulses != 6) begin
            tests_failed++;
            $display("[TB] FAIL repeat_count: got %0d expected 6", pulses);
        end
    endtask

    task automatic test_both_keys();
        logic [5:0] exp_pulse;
        int stray;
        do_reset();
        advance_mode();
        advance_mode();
        advance_mode();
        tests_run++;
        if (mode !== 2'd3) begin
            tests_failed++;
            $display("[TB] FAIL both_mode: got %0d expected 3", mode);
        end
        stray = 0;
        key_up_n = 1'b0;
        key_dn_n = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            if (inc !== 3'b000 || dec !== 3'b000) stray++;
        end
        tests_run++;
        if (stray != 0) begin
            tests_failed++;
            $display("[TB] FAIL both_held: got %0d pulse cycles expected 0", stray);
        end
        key_up_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            exp_pulse = (k == 8 || k == 12) ? 6'b000100 : 6'b000000;
            tests_run++;
            if ({inc, dec} !== exp_pulse) begin
                tests_failed++;
                $display("[TB] FAIL both_release[%0d]: got inc,dec %b expected %b", k, {inc, dec}, exp_pulse);
            end
        end
        key_dn_n = 1'b1;
        tick(2);
    endtask

    task automatic test_timeout();
        do_reset();
        advance_mode();
        tick(49);
        tests_run++;
        if (mode !== 2'd1 || freeze !== 3'b001) begin
            tests_failed++;
            $display("[TB] FAIL timeout_early: got mode %0d freeze %b expected mode 1 freeze 001", mode, freeze);
        end
        tick(1);
        tests_run++;
        if (mode !== 2'd0 || freeze !== 3'b000 || blank !== 6'b000000) begin
            tests_failed++;
            $display("[TB] FAIL timeout_hit: got mode %0d freeze %b blank %b expected 0 000 000000",
                     mode, freeze, blank);
        end
    endtask

    task automatic test_normal_keys();
        int stray;
        stray = 0;
        key_up_n = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            tick(1);
            if (inc !== 3'b000 || dec !== 3'b000) stray++;
        end
        tests_run++;
        if (stray != 0 || mode !== 2'd0) begin
            tests_failed++;
            $display("[TB] FAIL normal_keys: got %0d pulse cycles mode %0d expected 0 mode 0", stray, mode);
        end
        key_up_n = 1'b1;
        tick(2);
    endtask

    task automatic test_reset_mid_repeat();
        int stray;
        do_reset();
        advance_mode();
        advance_mode();
        key_up_n = 1'b0;
        tick(1);
        tests_run++;
        if (inc !== 3'b010) begin
            tests_failed++;
            $display("[TB] FAIL mid_press: got %b expected 010", inc);
        end
        tick(8);
        tests_run++;
        if (inc !== 3'b010) begin
            tests_failed++;
            $display("[TB] FAIL mid_repeat: got %b expected 010", inc);
        end
        reset = 1'b1;
        #1;
        tests_run++;
        if ({mode, inc, dec, freeze, blank} !== 17'd0) begin
            tests_failed++;
            $display("[TB] FAIL mid_async_reset: got %h expected 0", {mode, inc, dec, freeze, blank});
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        stray = 0;
        for (int k = 1; k <= 3; k++) begin
            tick(1);
            if (inc !== 3'b000 || dec !== 3'b000) stray++;
        end
        advance_mode();
        if (inc !== 3'b000 || dec !== 3'b000) stray++;
        advance_mode();
        tests_run++;
        if (mode !== 2'd2) begin
            tests_failed++;
            $display("[TB] FAIL lock_mode: got %0d expected 2", mode);
        end
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            if (inc !== 3'b000 || dec !== 3'b000) stray++;
        end
        tests_run++;
        if (stray != 0) begin
            tests_failed++;
            $display("[TB] FAIL lockout: got %0d pulse cycles expected 0", stray);
        end
        key_up_n = 1'b1;
        tick(2);
        key_up_n = 1'b0;
        tick(1);
        tests_run++;
        if (inc !== 3'b010 || dec !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL repress: got inc %b dec %b expected inc 010 dec 000", inc, dec);
        end
        key_up_n = 1'b1;
        tick(2);
    endtask

    initial begin
        test_reset();
        test_mode_cycle();
        test_single_press();
        test_repeat();
        test_both_keys();
        test_timeout();
        test_normal_keys();
        test_reset_mid_repeat();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
